vector_element_sequencer: RTL and testbench

Control-side partner of the vector element counter: accepts one decoded vector instruction at a time from decode, drives the counter's control inputs (`vstart`, `vl`, `sew`, `de_en`, `stall`, `clear`, `ex_return`), consumes its `offset`/`done`, and emits one per-element micro-op per cycle toward vector execute over a valid/ready handshake. Sits between vector decode and the vector lane issue logic; owns the trap and resume flow for partially completed instructions.

---
 rtl/vector_element_sequencer_if.sv | 27 ++
 rtl/vector_element_sequencer.sv | 135 +++++++++++++
 tb/tb_vector_element_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_element_sequencer_if.sv
// Decode-side instruction handshake and execute-side micro-op handshake of the
// vector element sequencer. The sequencer uses the slave modport.
interface vector_element_sequencer_if #(
  parameter int OFFSET_W = 5
);
  logic                inst_valid;
  logic                inst_ready;
  logic [31:0]         inst_vl;
  logic [31:0]         inst_vstart;
  logic [1:0]          inst_sew;

  logic                uop_valid;
  logic                uop_ready;
  logic [OFFSET_W-1:0] uop_offset;
  logic [31:0]         uop_index;
  logic                uop_last;

  modport slave (
    input  inst_valid, inst_vl, inst_vstart, inst_sew, uop_ready,
    output inst_ready, uop_valid, uop_offset, uop_index, uop_last
  );

  modport master (
    output inst_valid, inst_vl, inst_vstart, inst_sew, uop_ready,
    input  inst_ready, uop_valid, uop_offset, uop_index, uop_last
  );
endinterface

// File: rtl/vector_element_sequencer.sv
// Sequences one vector instruction into per-element micro-ops, drives the element
// counter, and handles trap/resume. Optional counter cross-check: VSEQ_COUNTER_CHECK_EN.
module vector_element_sequencer #(
  parameter int OFFSET_W = 5
) (
  input  logic                        CLK,
  input  logic                        RST,
  vector_element_sequencer_if.slave   bus,
  output logic [31:0]                 ec_vl,
  output logic [31:0]                 ec_vstart,
  output logic [1:0]                  ec_sew,
  output logic                        ec_de_en,
  output logic                        ec_stall,
  output logic                        ec_clear,
  output logic                        ec_ex_return,
  input  logic [OFFSET_W-1:0]         ec_offset,
  input  logic                        ec_done,
  input  logic                        exception,
  input  logic [31:0]                 ex_vstart,
  input  logic                        ex_return,
  output logic [31:0]                 vstart_out,
  output logic                        busy,
  output logic                        seq_err
);

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, TRAP} state_t;

  state_t      state, state_nx;
  logic [31:0] vl_q, vs_q, idx, saved;
  logic [1:0]  sew_q;
  logic        accept, start, trap, resume, last;

  assign accept = (state == IDLE) && bus.inst_valid;
  assign start  = accept && (bus.inst_vstart < bus.inst_vl);
  // vl_q==0 never reaches ISSUE, but guard the decrement anyway
  assign last   = (vl_q != 32'd0) && (idx == vl_q - 32'd1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.inst_ready = 1'b0;
    bus.uop_valid  = 1'b0;
    ec_clear       = 1'b0;
    ec_de_en       = 1'b0;
    ec_ex_return   = 1'b0;
    trap           = 1'b0;
    resume         = 1'b0;
    case (state)
      IDLE: begin
        bus.inst_ready = 1'b1;
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        ec_clear = 1'b1;
        if (exception) begin
          trap     = 1'b1;
          state_nx = TRAP;
        end else begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        bus.uop_valid = 1'b1;
        // a fault on the presented element wins over its handshake
        if (exception) begin
          trap     = 1'b1;
          state_nx = TRAP;
        end else if (bus.uop_ready) begin
          ec_de_en = 1'b1;
          if (last) state_nx = IDLE;
        end
      end
      TRAP: begin
        if (ex_return) begin
          ec_ex_return = 1'b1;
          resume       = 1'b1;
          state_nx     = LOAD;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vl_q  <= '0;
      vs_q  <= '0;
      sew_q <= '0;
      idx   <= '0;
      saved <= '0;
    end else begin
      if (accept) begin
        vl_q  <= bus.inst_vl;
        vs_q  <= bus.inst_vstart;
        sew_q <= bus.inst_sew;
      end
      if (start)    idx   <= bus.inst_vstart;
      if (ec_de_en) idx   <= idx + 32'd1;
      if (trap)     saved <= ex_vstart;
      if (resume) begin
        vs_q <= saved;
        idx  <= saved;
      end
    end
  end

  assign ec_vl          = vl_q;
  assign ec_vstart      = vs_q;
  assign ec_sew         = sew_q;
  assign ec_stall       = bus.uop_valid & ~bus.uop_ready;
  assign bus.uop_index  = idx;
  assign bus.uop_offset = bus.uop_valid ? ec_offset : '0;
  assign bus.uop_last   = bus.uop_valid & last;
  assign vstart_out     = saved;
  assign busy           = (state != IDLE);

`ifdef VSEQ_COUNTER_CHECK_EN
  logic [OFFSET_W-1:0] exp_off;
  assign exp_off = OFFSET_W'(idx << sew_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) seq_err <= 1'b0;
    else if (ec_de_en && ((ec_done != last) || (ec_offset != exp_off))) seq_err <= 1'b1;
  end
`else
  logic unused_done;
  assign unused_done = ec_done;
  assign seq_err     = 1'b0;
`endif

endmodule

// File: tb/tb_vector_element_sequencer.sv
// Self-checking bench for vector_element_sequencer with a behavioural element counter.
module tb_vector_element_sequencer;
  localparam int OW = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [31:0]   ec_vl, ec_vstart, ex_vstart, vstart_out;
  logic [1:0]    ec_sew;
  logic          ec_de_en, ec_stall, ec_clear, ec_ex_return, ec_done;
  logic [OW-1:0] ec_offset;
  logic          exception, ex_return, busy, seq_err, force_done;

  always #5 CLK = ~CLK;

  vector_element_sequencer_if #(.OFFSET_W(OW)) bus ();

  vector_element_sequencer #(.OFFSET_W(OW)) dut (
    .CLK(CLK), .RST(RST), .bus(bus),
    .ec_vl(ec_vl), .ec_vstart(ec_vstart), .ec_sew(ec_sew),
    .ec_de_en(ec_de_en), .ec_stall(ec_stall), .ec_clear(ec_clear),
    .ec_ex_return(ec_ex_return), .ec_offset(ec_offset), .ec_done(ec_done),
    .exception(exception), .ex_vstart(ex_vstart), .ex_return(ex_return),
    .vstart_out(vstart_out), .busy(busy), .seq_err(seq_err)
  );

  // element counter model
  logic [31:0] cnt;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           cnt <= '0;
    else if (ec_clear) cnt <= ec_vstart;
    else if (ec_de_en) cnt <= cnt + 32'd1;
  end
  assign ec_offset = OW'(cnt << ec_sew);
  assign ec_done   = ((ec_vl != 0) && (cnt == ec_vl - 32'd1)) | force_done;

  typedef struct {
    logic [31:0]   idx;
    logic [OW-1:0] off;
    logic          last;
  } uop_t;

  typedef struct {
    int unsigned vl;
    int unsigned vstart;
    logic [1:0]  sew;
    int          n_uops;
  } vec_t;

  uop_t sb[$];
  uop_t e_m;
  int   n_cmp = 0, n_err = 0;
  int   n_uop, n_de, n_clr, n_exr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (ec_de_en)     n_de++;
      if (ec_clear)     n_clr++;
      if (ec_ex_return) n_exr++;
      if (bus.uop_valid && bus.uop_ready && !exception) begin
        n_uop++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL uop_unexpected: got index %0d want none", bus.uop_index);
        end else begin
          e_m = sb.pop_front();
          check("uop_index",  bus.uop_index,  e_m.idx);
          check("uop_offset", bus.uop_offset, e_m.off);
          check("uop_last",   bus.uop_last,   e_m.last);
        end
      end
    end
  end

  task automatic clr_counts();
    n_uop = 0; n_de = 0; n_clr = 0; n_exr = 0;
  endtask

  task automatic issue(input int unsigned vl, input int unsigned vs, input logic [1:0] sew);
    @(posedge CLK); #1;
    bus.inst_valid  = 1'b1;
    bus.inst_vl     = vl;
    bus.inst_vstart = vs;
    bus.inst_sew    = sew;
    for (int unsigned i = vs; i < vl; i++) begin
      uop_t u;
      u.idx  = i;
      u.off  = OW'(i << sew);
      u.last = (i == vl - 1);
      sb.push_back(u);
    end
    @(posedge CLK); #1;
    bus.inst_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge CLK);
      if (!busy) ok = 1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL wait_idle: got busy want idle");
    end
  endtask

  task automatic wait_index(input int unsigned k);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge CLK);
      if (bus.uop_valid && bus.uop_index == k) ok = 1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL wait_index: got timeout want index %0d", k);
    end
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{vl: 4,  vstart: 0, sew: 2'd2, n_uops: 4};
    tbl[1] = '{vl: 8,  vstart: 8, sew: 2'd0, n_uops: 0};
    tbl[2] = '{vl: 0,  vstart: 0, sew: 2'd1, n_uops: 0};
    tbl[3] = '{vl: 3,  vstart: 1, sew: 2'd1, n_uops: 2};
    tbl[4] = '{vl: 5,  vstart: 2, sew: 2'd0, n_uops: 3};
    tbl[5] = '{vl: 1,  vstart: 0, sew: 2'd2, n_uops: 1};
    tbl[6] = '{vl: 2,  vstart: 7, sew: 2'd0, n_uops: 0};

    bus.inst_valid = 0; bus.inst_vl = 0; bus.inst_vstart = 0; bus.inst_sew = 0;
    bus.uop_ready = 1; exception = 0; ex_return = 0; ex_vstart = 0; force_done = 0;
    clr_counts();

    // reset state
    @(negedge CLK);
    check("rst_inst_ready", bus.inst_ready, 1);
    check("rst_uop_valid",  bus.uop_valid, 0);
    check("rst_busy",       busy, 0);
    check("rst_ec_clear",   ec_clear, 0);
    check("rst_vstart_out", vstart_out, 0);
    check("rst_ec_vl",      ec_vl, 0);
    check("rst_seq_err",    seq_err, 0);
    @(posedge CLK); #1 RST = 0;

    foreach (tbl[k]) begin
      clr_counts();
      issue(tbl[k].vl, tbl[k].vstart, tbl[k].sew);
      @(negedge CLK);
      check("t1_ec_clear", ec_clear, tbl[k].n_uops > 0);
      check("t1_busy",     busy,     tbl[k].n_uops > 0);
      @(negedge CLK);
      check("t2_uop_valid", bus.uop_valid, tbl[k].n_uops > 0);
      wait_idle();
      check("tbl_uops",  n_uop, tbl[k].n_uops);
      check("tbl_de_en", n_de,  tbl[k].n_uops);
      check("tbl_clear", n_clr, tbl[k].n_uops > 0);
      check("tbl_sb",    sb.size(), 0);
      check("tbl_ec_vl", ec_vl, tbl[k].vl);
      check("tbl_seq_err", seq_err, 0);
    end

    // back-pressure: index 2 held for three cycles
    clr_counts();
    issue(6, 0, 2'd0);
    wait_index(1);
    @(posedge CLK); #1 bus.uop_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("stall_valid",  bus.uop_valid, 1);
      check("stall_index",  bus.uop_index, 2);
      check("stall_offset", bus.uop_offset, 2);
      check("stall_ec",     ec_stall, 1);
      check("stall_de_en",  ec_de_en, 0);
    end
    @(posedge CLK); #1 bus.uop_ready = 1;
    wait_idle();
    check("stall_uops", n_uop, 6);
    check("stall_de",   n_de, 6);

    // fault at index 5 concurrent with handshake, then resume
    clr_counts();
    issue(10, 0, 2'd1);
    wait_index(4);
    @(posedge CLK); #1 exception = 1; ex_vstart = 5;
    @(negedge CLK);
    check("exc_index", bus.uop_index, 5);
    check("exc_de_en", ec_de_en, 0);
    @(posedge CLK); #1 exception = 0;
    @(negedge CLK);
    check("trap_busy",       busy, 1);
    check("trap_uop_valid",  bus.uop_valid, 0);
    check("trap_inst_ready", bus.inst_ready, 0);
    check("trap_vstart_out", vstart_out, 5);
    repeat (2) @(posedge CLK);
    #1 ex_return = 1;
    @(negedge CLK);
    check("ret_pulse", ec_ex_return, 1);
    @(posedge CLK); #1 ex_return = 0;
    @(negedge CLK);
    check("ret_clear",  ec_clear, 1);
    check("ret_vstart", ec_vstart, 5);
    @(negedge CLK);
    check("ret_valid", bus.uop_valid, 1);
    check("ret_index", bus.uop_index, 5);
    wait_idle();
    check("exc_uops", n_uop, 10);
    check("exc_de",   n_de, 10);
    check("exc_exr",  n_exr, 1);
    check("exc_sb",   sb.size(), 0);

    // reset mid-operation
    clr_counts();
    issue(16, 0, 2'd2);
    wait_index(3);
    #1 RST = 1;
    @(negedge CLK);
    check("mrst_uop_valid",  bus.uop_valid, 0);
    check("mrst_inst_ready", bus.inst_ready, 1);
    check("mrst_busy",       busy, 0);
    check("mrst_vstart_out", vstart_out, 0);
    sb.delete();
    @(posedge CLK); #1 RST = 0;

`ifdef VSEQ_COUNTER_CHECK_EN
    // counter disagrees with sequencer at index 1
    clr_counts();
    issue(4, 0, 2'd2);
    wait_index(0);
    @(posedge CLK); #1 force_done = 1;
    @(posedge CLK); #1 force_done = 0;
    @(negedge CLK);
    check("chk_seq_err", seq_err, 1);
    wait_idle();
    repeat (3) @(negedge CLK);
    check("chk_sticky", seq_err, 1);
    #1 RST = 1;
    @(negedge CLK);
    check("chk_rst", seq_err, 0);
    @(posedge CLK); #1 RST = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
